// File: rtl/riscv_multicycle_ctrl.sv
// Multicycle control unit for the 64-bit RISC-V datapath: sequences fetch/decode/execute/memory/writeback.
// Optional macro CTRL_INSTRET_EN adds a 64-bit retired-instruction counter output (instret).
module riscv_multicycle_ctrl #(
  parameter int MEM_LATENCY = 1,
  parameter int INSTR_W     = 32
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        alu_zero,
  output logic        pc_write,
  output logic        ir_load,
  output logic        ab_load,
  output logic        aluout_load,
  output logic        mem_instr_wr,
  output logic        mem_data_wr,
  output logic        mem_data_rd,
  output logic        reg_write,
  output logic [2:0]  alu_sel,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  pc_src,
  output logic [1:0]  wb_src,
  output logic [3:0]  state,
  output logic        trap
`ifdef CTRL_INSTRET_EN
  ,
  output logic [63:0] instret
`endif
);

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,  S_FETCH  = 4'd1,  S_DECODE = 4'd2,  S_EXEC_R = 4'd3,
    S_EXEC_I = 4'd4,  S_ADDR   = 4'd5,  S_MEM_RD = 4'd6,  S_MEM_WR = 4'd7,
    S_WB_ALU = 4'd8,  S_WB_MEM = 4'd9,  S_BRANCH = 4'd10, S_JAL    = 4'd11,
    S_JALR   = 4'd12, S_LUI    = 4'd13, S_TRAP   = 4'd14
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       ir_load;
    logic       ab_load;
    logic       aluout_load;
    logic       mem_data_wr;
    logic       mem_data_rd;
    logic       reg_write;
    logic       trap;
    logic [2:0] alu_sel;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [1:0] wb_src;
  } ctl_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] LAT = 3'(MEM_LATENCY);
  // funct7b5 lives in instruction bit 30; a narrower word cannot be decoded.
  localparam logic DECODE_OK = (INSTR_W >= 31);

  function automatic logic f3_legal(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b111) || (f3 == 3'b100) || (f3 == 3'b110);
  endfunction

  function automatic logic [2:0] alu_op(input logic [2:0] f3, input logic sub);
    case (f3)
      3'b000:  return sub ? 3'b010 : 3'b001;
      3'b111:  return 3'b011;
      3'b100:  return 3'b100;
      3'b110:  return 3'b110;
      default: return 3'b000;
    endcase
  endfunction

  state_t     state_q, state_nxt;
  logic [2:0] cnt_q, cnt_nxt;
  ctl_t       ctl_q, ctl_nxt;
  logic       branch_take;

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_RESET:  state_nxt = S_FETCH;
      S_FETCH:  if (cnt_q == LAT) state_nxt = S_DECODE;
      S_DECODE: begin
        if (!DECODE_OK) state_nxt = S_TRAP;
        else begin
          case (opcode)
            OP_R:               state_nxt = S_EXEC_R;
            OP_I:               state_nxt = S_EXEC_I;
            OP_LOAD, OP_STORE:  state_nxt = S_ADDR;
            OP_BRANCH:          state_nxt = S_BRANCH;
            OP_JAL:             state_nxt = S_JAL;
            OP_JALR:            state_nxt = S_JALR;
            OP_LUI:             state_nxt = S_LUI;
            default:            state_nxt = S_TRAP;
          endcase
        end
      end
      S_EXEC_R, S_EXEC_I: state_nxt = f3_legal(funct3) ? S_WB_ALU : S_TRAP;
      S_ADDR:   state_nxt = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: if (cnt_q == LAT) state_nxt = S_WB_MEM;
      S_MEM_WR, S_WB_ALU, S_WB_MEM, S_JAL, S_JALR: state_nxt = S_FETCH;
      S_BRANCH: state_nxt = (funct3[2:1] == 2'b00) ? S_FETCH : S_TRAP;
      S_LUI:    state_nxt = S_WB_ALU;
      S_TRAP:   state_nxt = S_TRAP;
      default:  state_nxt = S_TRAP;
    endcase
  end

  // Wait counter only runs while a memory-timed state repeats itself.
  always_comb begin
    cnt_nxt = 3'd0;
    if ((state_nxt == state_q) && ((state_q == S_FETCH) || (state_q == S_MEM_RD)))
      cnt_nxt = cnt_q + 3'd1;
  end

  // Outputs are decoded from the next state and registered, so they line up with state_q.
  always_comb begin
    ctl_nxt = '0;
    case (state_nxt)
      S_FETCH: if (cnt_nxt == LAT) begin
        ctl_nxt.pc_write  = 1'b1;
        ctl_nxt.ir_load   = 1'b1;
        ctl_nxt.alu_sel   = 3'b001;
        ctl_nxt.alu_src_b = 2'b01;
      end
      S_DECODE: begin
        ctl_nxt.ab_load     = 1'b1;
        ctl_nxt.aluout_load = 1'b1;
        ctl_nxt.alu_sel     = 3'b001;
        ctl_nxt.alu_src_a   = 2'b01;
        ctl_nxt.alu_src_b   = 2'b10;
      end
      S_EXEC_R: begin
        ctl_nxt.aluout_load = 1'b1;
        ctl_nxt.alu_sel     = alu_op(funct3, funct7b5);
        ctl_nxt.alu_src_a   = 2'b10;
      end
      S_EXEC_I: begin
        ctl_nxt.aluout_load = 1'b1;
        ctl_nxt.alu_sel     = alu_op(funct3, 1'b0);
        ctl_nxt.alu_src_a   = 2'b10;
        ctl_nxt.alu_src_b   = 2'b10;
      end
      S_ADDR: begin
        ctl_nxt.aluout_load = 1'b1;
        ctl_nxt.alu_sel     = 3'b001;
        ctl_nxt.alu_src_a   = 2'b10;
        ctl_nxt.alu_src_b   = 2'b10;
      end
      S_MEM_RD: ctl_nxt.mem_data_rd = 1'b1;
      S_MEM_WR: ctl_nxt.mem_data_wr = 1'b1;
      S_WB_ALU: ctl_nxt.reg_write   = 1'b1;
      S_WB_MEM: begin
        ctl_nxt.reg_write = 1'b1;
        ctl_nxt.wb_src    = 2'b01;
      end
      S_BRANCH: begin
        ctl_nxt.alu_sel   = 3'b010;
        ctl_nxt.alu_src_a = 2'b10;
        ctl_nxt.pc_src    = 2'b01;
      end
      S_JAL: begin
        ctl_nxt.reg_write = 1'b1;
        ctl_nxt.wb_src    = 2'b10;
        ctl_nxt.pc_write  = 1'b1;
        ctl_nxt.pc_src    = 2'b01;
      end
      S_JALR: begin
        ctl_nxt.reg_write = 1'b1;
        ctl_nxt.wb_src    = 2'b10;
        ctl_nxt.pc_write  = 1'b1;
        ctl_nxt.pc_src    = 2'b10;
        ctl_nxt.alu_sel   = 3'b001;
        ctl_nxt.alu_src_a = 2'b10;
        ctl_nxt.alu_src_b = 2'b10;
      end
      S_LUI: begin
        ctl_nxt.aluout_load = 1'b1;
        ctl_nxt.alu_sel     = 3'b000;
        ctl_nxt.alu_src_b   = 2'b10;
      end
      S_TRAP:  ctl_nxt.trap = 1'b1;
      default: ctl_nxt = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_RESET;
      cnt_q   <= 3'd0;
      ctl_q   <= '0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      ctl_q   <= ctl_nxt;
    end
  end

  // Branch outcome needs the live zero flag, so this is the one combinational enable.
  assign branch_take = (state_q == S_BRANCH) &&
                       (((funct3 == 3'b000) && alu_zero) || ((funct3 == 3'b001) && !alu_zero));

  assign pc_write     = ctl_q.pc_write | branch_take;
  assign ir_load      = ctl_q.ir_load;
  assign ab_load      = ctl_q.ab_load;
  assign aluout_load  = ctl_q.aluout_load;
  assign mem_instr_wr = 1'b0;
  assign mem_data_wr  = ctl_q.mem_data_wr;
  assign mem_data_rd  = ctl_q.mem_data_rd;
  assign reg_write    = ctl_q.reg_write;
  assign alu_sel      = ctl_q.alu_sel;
  assign alu_src_a    = ctl_q.alu_src_a;
  assign alu_src_b    = ctl_q.alu_src_b;
  assign pc_src       = ctl_q.pc_src;
  assign wb_src       = ctl_q.wb_src;
  assign trap         = ctl_q.trap;
  assign state        = state_q;

`ifdef CTRL_INSTRET_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) instret <= 64'd0;
    else if ((state_nxt == S_FETCH) && (state_q != S_FETCH) &&
             (state_q != S_RESET) && (state_q != S_TRAP))
      instret <= instret + 64'd1;
  end
`endif

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Self-checking bench for riscv_multicycle_ctrl: three instances at MEM_LATENCY 1, 2 and 0.
module tb_riscv_multicycle_ctrl;

  localparam logic [3:0] ST_RESET = 4'd0,  ST_FETCH = 4'd1,  ST_DECODE = 4'd2, ST_EXEC_R = 4'd3,
                         ST_EXEC_I = 4'd4, ST_ADDR = 4'd5,   ST_MEM_RD = 4'd6, ST_MEM_WR = 4'd7,
                         ST_WB_ALU = 4'd8, ST_WB_MEM = 4'd9, ST_BRANCH = 4'd10, ST_JAL = 4'd11,
                         ST_JALR = 4'd12,  ST_LUI = 4'd13,   ST_TRAP = 4'd14;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LOAD = 7'b0000011,
                         OP_STORE = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_BAD = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst_a, rst_b, rst_c;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5, alu_zero;

  logic       pc_write_a, ir_load_a, ab_load_a, aluout_load_a, mem_instr_wr_a, mem_data_wr_a;
  logic       mem_data_rd_a, reg_write_a, trap_a;
  logic [2:0] alu_sel_a;
  logic [1:0] alu_src_a_a, alu_src_b_a, pc_src_a, wb_src_a;
  logic [3:0] state_a;
  logic       pc_write_b, ir_load_b, ab_load_b, aluout_load_b, mem_instr_wr_b, mem_data_wr_b;
  logic       mem_data_rd_b, reg_write_b, trap_b;
  logic [2:0] alu_sel_b;
  logic [1:0] alu_src_a_b, alu_src_b_b, pc_src_b, wb_src_b;
  logic [3:0] state_b;
  logic       pc_write_c, ir_load_c, ab_load_c, aluout_load_c, mem_instr_wr_c, mem_data_wr_c;
  logic       mem_data_rd_c, reg_write_c, trap_c;
  logic [2:0] alu_sel_c;
  logic [1:0] alu_src_a_c, alu_src_b_c, pc_src_c, wb_src_c;
  logic [3:0] state_c;
`ifdef CTRL_INSTRET_EN
  logic [63:0] instret_a, instret_b, instret_c;
`endif

  logic [23:0] obs_a, obs_b, obs_c;
  assign obs_a = {pc_write_a, ir_load_a, ab_load_a, aluout_load_a, mem_instr_wr_a, mem_data_wr_a,
                  mem_data_rd_a, reg_write_a, alu_sel_a, alu_src_a_a, alu_src_b_a, pc_src_a,
                  wb_src_a, state_a, trap_a};
  assign obs_b = {pc_write_b, ir_load_b, ab_load_b, aluout_load_b, mem_instr_wr_b, mem_data_wr_b,
                  mem_data_rd_b, reg_write_b, alu_sel_b, alu_src_a_b, alu_src_b_b, pc_src_b,
                  wb_src_b, state_b, trap_b};
  assign obs_c = {pc_write_c, ir_load_c, ab_load_c, aluout_load_c, mem_instr_wr_c, mem_data_wr_c,
                  mem_data_rd_c, reg_write_c, alu_sel_c, alu_src_a_c, alu_src_b_c, pc_src_c,
                  wb_src_c, state_c, trap_c};

  riscv_multicycle_ctrl #(.MEM_LATENCY(1), .INSTR_W(32)) dut_a (
    .CLK(clk), .RST(rst_a), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .alu_zero(alu_zero), .pc_write(pc_write_a), .ir_load(ir_load_a), .ab_load(ab_load_a),
    .aluout_load(aluout_load_a), .mem_instr_wr(mem_instr_wr_a), .mem_data_wr(mem_data_wr_a),
    .mem_data_rd(mem_data_rd_a), .reg_write(reg_write_a), .alu_sel(alu_sel_a),
    .alu_src_a(alu_src_a_a), .alu_src_b(alu_src_b_a), .pc_src(pc_src_a), .wb_src(wb_src_a),
    .state(state_a), .trap(trap_a)
`ifdef CTRL_INSTRET_EN
    , .instret(instret_a)
`endif
  );

  riscv_multicycle_ctrl #(.MEM_LATENCY(2), .INSTR_W(32)) dut_b (
    .CLK(clk), .RST(rst_b), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .alu_zero(alu_zero), .pc_write(pc_write_b), .ir_load(ir_load_b), .ab_load(ab_load_b),
    .aluout_load(aluout_load_b), .mem_instr_wr(mem_instr_wr_b), .mem_data_wr(mem_data_wr_b),
    .mem_data_rd(mem_data_rd_b), .reg_write(reg_write_b), .alu_sel(alu_sel_b),
    .alu_src_a(alu_src_a_b), .alu_src_b(alu_src_b_b), .pc_src(pc_src_b), .wb_src(wb_src_b),
    .state(state_b), .trap(trap_b)
`ifdef CTRL_INSTRET_EN
    , .instret(instret_b)
`endif
  );

  riscv_multicycle_ctrl #(.MEM_LATENCY(0), .INSTR_W(32)) dut_c (
    .CLK(clk), .RST(rst_c), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .alu_zero(alu_zero), .pc_write(pc_write_c), .ir_load(ir_load_c), .ab_load(ab_load_c),
    .aluout_load(aluout_load_c), .mem_instr_wr(mem_instr_wr_c), .mem_data_wr(mem_data_wr_c),
    .mem_data_rd(mem_data_rd_c), .reg_write(reg_write_c), .alu_sel(alu_sel_c),
    .alu_src_a(alu_src_a_c), .alu_src_b(alu_src_b_c), .pc_src(pc_src_c), .wb_src(wb_src_c),
    .state(state_c), .trap(trap_c)
`ifdef CTRL_INSTRET_EN
    , .instret(instret_c)
`endif
  );

  // Clock / reset
  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [23:0] exp_q[$];

  function automatic logic [23:0] ov(input logic [3:0] st, input logic pcw, input logic irl,
                                     input logic abl, input logic aol, input logic mdw,
                                     input logic mdr, input logic rw, input logic [2:0] asel,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [1:0] ps, input logic [1:0] wb, input logic tr);
    return {pcw, irl, abl, aol, 1'b0, mdw, mdr, rw, asel, sa, sb, ps, wb, st, tr};
  endfunction

  function automatic logic [23:0] obs(input int sel);
    case (sel)
      0:       return obs_a;
      1:       return obs_b;
      default: return obs_c;
    endcase
  endfunction

  function automatic int lat_of(input int sel);
    case (sel)
      0:       return 1;
      1:       return 2;
      default: return 0;
    endcase
  endfunction

  task automatic push_trap(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(ov(ST_TRAP, 0,0,0,0,0,0,0, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 1));
  endtask

  // Reference model: per-cycle expected control word for one instruction.
  task automatic push_model(input int lat, input logic [6:0] opc, input logic [2:0] f3,
                            input logic f7, input logic z, input int ntrap);
    logic       is_r, take;
    logic [2:0] asel;
    for (int c = 0; c <= lat; c++)
      if (c == lat) exp_q.push_back(ov(ST_FETCH, 1,1,0,0,0,0,0, 3'b001, 2'b00, 2'b01, 2'b00, 2'b00, 0));
      else          exp_q.push_back(ov(ST_FETCH, 0,0,0,0,0,0,0, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 0));
    exp_q.push_back(ov(ST_DECODE, 0,0,1,1,0,0,0, 3'b001, 2'b01, 2'b10, 2'b00, 2'b00, 0));
    case (opc)
      OP_R, OP_I: begin
        is_r = (opc == OP_R);
        case (f3)
          3'b000:  asel = (is_r && f7) ? 3'b010 : 3'b001;
          3'b111:  asel = 3'b011;
          3'b100:  asel = 3'b100;
          3'b110:  asel = 3'b110;
          default: asel = 3'b000;
        endcase
        exp_q.push_back(ov(is_r ? ST_EXEC_R : ST_EXEC_I, 0,0,0,1,0,0,0, asel, 2'b10,
                           is_r ? 2'b00 : 2'b10, 2'b00, 2'b00, 0));
        if (f3 inside {3'b000, 3'b111, 3'b100, 3'b110})
          exp_q.push_back(ov(ST_WB_ALU, 0,0,0,0,0,0,1, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 0));
        else push_trap(ntrap);
      end
      OP_LOAD, OP_STORE: begin
        exp_q.push_back(ov(ST_ADDR, 0,0,0,1,0,0,0, 3'b001, 2'b10, 2'b10, 2'b00, 2'b00, 0));
        if (opc == OP_LOAD) begin
          for (int c = 0; c <= lat; c++)
            exp_q.push_back(ov(ST_MEM_RD, 0,0,0,0,0,1,0, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 0));
          exp_q.push_back(ov(ST_WB_MEM, 0,0,0,0,0,0,1, 3'b000, 2'b00, 2'b00, 2'b00, 2'b01, 0));
        end else
          exp_q.push_back(ov(ST_MEM_WR, 0,0,0,0,1,0,0, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 0));
      end
      OP_BR: begin
        take = ((f3 == 3'b000) && z) || ((f3 == 3'b001) && !z);
        exp_q.push_back(ov(ST_BRANCH, take,0,0,0,0,0,0, 3'b010, 2'b10, 2'b00, 2'b01, 2'b00, 0));
        if (f3 > 3'b001) push_trap(ntrap);
      end
      OP_JAL:  exp_q.push_back(ov(ST_JAL, 1,0,0,0,0,0,1, 3'b000, 2'b00, 2'b00, 2'b01, 2'b10, 0));
      OP_JALR: exp_q.push_back(ov(ST_JALR, 1,0,0,0,0,0,1, 3'b001, 2'b10, 2'b10, 2'b10, 2'b10, 0));
      OP_LUI: begin
        exp_q.push_back(ov(ST_LUI, 0,0,0,1,0,0,0, 3'b000, 2'b00, 2'b10, 2'b00, 2'b00, 0));
        exp_q.push_back(ov(ST_WB_ALU, 0,0,0,0,0,0,1, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 0));
      end
      default: push_trap(ntrap);
    endcase
  endtask

  // Driver + scoreboard: one instruction, compared cycle by cycle on the falling edge.
  task automatic exec(input int sel, input string name, input logic [6:0] opc, input logic [2:0] f3,
                      input logic f7, input logic z, input int ntrap);
    int          n;
    logic [23:0] got, exp;
    push_model(lat_of(sel), opc, f3, f7, z, ntrap);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      got = obs(sel);
      exp = exp_q.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL %s dut%0d cycle %0d: got %h want %h", name, sel, i + 1, got, exp);
      end
      if (i == 0) begin
        opcode = opc; funct3 = f3; funct7b5 = f7; alu_zero = z;
      end
    end
  endtask

  task automatic check_idle(input int sel, input string name);
    vectors++;
    if (obs(sel) !== 24'h0) begin
      miscompares++;
      $display("FAIL %s dut%0d: got %h want %h", name, sel, obs(sel), 24'h0);
    end
  endtask

  task automatic test_reset;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    opcode = OP_R; funct3 = 3'b000; funct7b5 = 1'b0; alu_zero = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle(0, "reset_hold"); check_idle(1, "reset_hold"); check_idle(2, "reset_hold");
    end
    rst_a = 1'b1;
    #1 check_idle(0, "reset_release");
  endtask

  task automatic test_alu;
    exec(0, "add",  OP_R, 3'b000, 1'b0, 1'b0, 0);
    exec(0, "sub",  OP_R, 3'b000, 1'b1, 1'b0, 0);
    exec(0, "and",  OP_R, 3'b111, 1'b0, 1'b0, 0);
    exec(0, "xor",  OP_R, 3'b100, 1'b1, 1'b0, 0);
    exec(0, "or",   OP_R, 3'b110, 1'b0, 1'b0, 0);
    exec(0, "addi", OP_I, 3'b000, 1'b1, 1'b0, 0);
    exec(0, "ori",  OP_I, 3'b110, 1'b0, 1'b1, 0);
  endtask

  task automatic test_branch;
    exec(0, "beq_z1", OP_BR, 3'b000, 1'b0, 1'b1, 0);
    exec(0, "beq_z0", OP_BR, 3'b000, 1'b0, 1'b0, 0);
    exec(0, "bne_z1", OP_BR, 3'b001, 1'b0, 1'b1, 0);
    exec(0, "bne_z0", OP_BR, 3'b001, 1'b0, 1'b0, 0);
  endtask

  task automatic test_jump;
    exec(0, "jal",  OP_JAL,  3'b000, 1'b0, 1'b0, 0);
    exec(0, "jalr", OP_JALR, 3'b000, 1'b0, 1'b0, 0);
    exec(0, "lui",  OP_LUI,  3'b000, 1'b0, 1'b0, 0);
  endtask

  task automatic test_back_to_back;
    logic [6:0] ops[8];
    logic [2:0] f3s[4];
    logic [6:0] opc;
    logic [2:0] f3;
    ops = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR, OP_JAL, OP_JALR, OP_LUI};
    f3s = '{3'b000, 3'b111, 3'b100, 3'b110};
    for (int i = 0; i < 20; i++) begin
      opc = ops[$urandom_range(0, 7)];
      f3  = (opc == OP_BR) ? 3'($urandom_range(0, 1)) : f3s[$urandom_range(0, 3)];
      exec(0, "b2b", opc, f3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    end
  endtask

  task automatic test_trap;
    exec(0, "trap", OP_BAD, 3'b000, 1'b0, 1'b0, 10);
    rst_a = 1'b0;
    #1 check_idle(0, "trap_reset");
  endtask

  task automatic test_mem_latency2;
    @(negedge clk);
    rst_b = 1'b1;
    #1 check_idle(1, "reset_release_l2");
    exec(1, "load_l2",  OP_LOAD,  3'b011, 1'b0, 1'b0, 0);
    exec(1, "store_l2", OP_STORE, 3'b011, 1'b0, 1'b0, 0);
    exec(1, "add_l2",   OP_R,     3'b000, 1'b0, 1'b0, 0);
  endtask

  task automatic test_reset_mid_store;
    exec(1, "store_pre_rst", OP_STORE, 3'b011, 1'b0, 1'b0, 0);
    #2 rst_b = 1'b0;
    #1 check_idle(1, "async_rst");
`ifdef CTRL_INSTRET_EN
    vectors++;
    if (instret_b !== 64'd0) begin
      miscompares++;
      $display("FAIL instret_clear: got %0d want 0", instret_b);
    end
`endif
    @(negedge clk);
    rst_b = 1'b1;
    #1 check_idle(1, "restart_release");
    exec(1, "restart_add",   OP_R,     3'b000, 1'b0, 1'b0, 0);
    exec(1, "restart_addi",  OP_I,     3'b100, 1'b0, 1'b0, 0);
    exec(1, "restart_store", OP_STORE, 3'b011, 1'b0, 1'b0, 0);
    @(negedge clk);
`ifdef CTRL_INSTRET_EN
    vectors++;
    if (instret_b !== 64'd3) begin
      miscompares++;
      $display("FAIL instret_count: got %0d want 3", instret_b);
    end
`endif
    vectors++;
    if (state_b !== ST_FETCH) begin
      miscompares++;
      $display("FAIL restart_next_fetch: got %0d want %0d", state_b, ST_FETCH);
    end
  endtask

  task automatic test_latency0;
    rst_b = 1'b0;
    @(negedge clk);
    rst_c = 1'b1;
    #1 check_idle(2, "reset_release_l0");
    exec(2, "add_l0",   OP_R,     3'b000, 1'b1, 1'b0, 0);
    exec(2, "load_l0",  OP_LOAD,  3'b010, 1'b0, 1'b0, 0);
    exec(2, "store_l0", OP_STORE, 3'b010, 1'b0, 1'b0, 0);
    exec(2, "bne_l0",   OP_BR,    3'b001, 1'b0, 1'b0, 0);
    exec(2, "jalr_l0",  OP_JALR,  3'b000, 1'b0, 1'b0, 0);
  endtask

  initial begin
    test_reset();
    test_alu();
    test_branch();
    test_jump();
    test_back_to_back();
    test_trap();
    test_mem_latency2();
    test_reset_mid_store();
    test_latency0();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
